// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
// Holds the FSM state encoding and the operand-magnitude helper.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Widest operand the magnitude helper supports.
    localparam int MAX_W = 64;

    // Magnitude of a width-bit value held zero-extended in MAX_W bits.
    // -2^(width-1) maps to 2^(width-1), which still fits in width unsigned bits.
    function automatic logic [MAX_W-1:0] abs_w(input logic [MAX_W-1:0] value,
                                               input int              width,
                                               input logic            mode);
        logic [MAX_W-1:0] mask;
        logic [MAX_W-1:0] mag;
        mask = (width >= MAX_W) ? '1 : ((MAX_W'(1) << width) - MAX_W'(1));
        if (mode && value[width-1])
            mag = (~value + MAX_W'(1)) & mask;
        else
            mag = value & mask;
        return mag;
    endfunction

endpackage

// File: rtl/param_multiplier.sv
// Parametrised shift-add multiplier with optional two's-complement mode.
// Fixed WIDTH-cycle latency; result and ready hold until the next accepted start.
module param_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] res,
    output logic               ready,
    output logic               busy,
    output logic [1:0]         state_dbg
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int PW = 2 * WIDTH;

    // Handshake: start is accepted on any rising edge while not in CALC;
    // ready marks res valid and stays high until the next accepted start.
    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic             neg;
    logic [PW-1:0]    acc;
    logic [CW-1:0]    cnt;

    logic             mode_in;
    logic             launch;
    logic             last_step;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [CW-1:0]    shamt;
    logic [PW-1:0]    addend;
    logic [PW-1:0]    acc_step;

    always_comb begin
        mode_in   = signed_mode & SIGNED_EN;
        a_mag     = WIDTH'(abs_w(MAX_W'(a), WIDTH, mode_in));
        b_mag     = WIDTH'(abs_w(MAX_W'(b), WIDTH, mode_in));
        launch    = (state != CALC) && start;
        last_step = (state == CALC) && (cnt == CW'(1));
        // Partial product weight grows by one bit per step as cnt counts down.
        shamt     = CW'(WIDTH) - cnt;
        addend    = mplier[0] ? (PW'(mcand) << shamt) : '0;
        acc_step  = acc + addend;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (cnt == CW'(1)) state_next = DONE;
            DONE:    if (start) state_next = CALC;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ready     = (state == DONE);
        busy      = (state == CALC);
        state_dbg = state;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand  <= '0;
            mplier <= '0;
            neg    <= 1'b0;
            acc    <= '0;
            cnt    <= '0;
            res    <= '0;
        end else if (launch) begin
            mcand  <= a_mag;
            mplier <= b_mag;
            neg    <= mode_in & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc    <= '0;
            cnt    <= CW'(WIDTH);
        end else if (state == CALC) begin
            acc    <= acc_step;
            mplier <= mplier >> 1;
            cnt    <= cnt - CW'(1);
            if (last_step)
                res <= neg ? (~acc_step + PW'(1)) : acc_step;
        end
    end

endmodule

// File: tb/tb_param_multiplier.sv
// Scoreboard bench for param_multiplier: directed vectors, WIDTH=4, with a
// signed-enabled and a signed-disabled instance sharing clock and reset.
module tb_param_multiplier;

    localparam int W  = 4;
    localparam int PW = 2 * W;

    logic          clk;
    logic          reset;
    logic          start,  start_u;
    logic          sm,     sm_u;
    logic [W-1:0]  a, b, a_u, b_u;
    logic [PW-1:0] res,    res_u;
    logic          ready,  ready_u;
    logic          busy,   busy_u;
    logic [1:0]    st_dbg, st_dbg_u;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;

    logic [PW-1:0] exp_q[$];
    int            launch_q[$];
    logic [PW-1:0] exp_u_q[$];
    int            launch_u_q[$];

    param_multiplier #(.WIDTH(W), .SIGNED_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .start(start), .signed_mode(sm),
        .a(a), .b(b), .res(res), .ready(ready), .busy(busy), .state_dbg(st_dbg)
    );

    param_multiplier #(.WIDTH(W), .SIGNED_EN(1'b0)) dut_u (
        .clk(clk), .reset(reset), .start(start_u), .signed_mode(sm_u),
        .a(a_u), .b(b_u), .res(res_u), .ready(ready_u), .busy(busy_u), .state_dbg(st_dbg_u)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- check helper ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total_cnt++;
        if (act === expv) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    endtask

    // ---------------- monitors ----------------
    logic ready_q = 1'b0, ready_u_q = 1'b0;

    always @(negedge clk) begin
        if (ready && !ready_q) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ready", 32'd1, 32'd0);
            end else begin
                check("res", 32'(res), 32'(exp_q.pop_front()));
                check("latency", 32'(cyc - launch_q.pop_front()), 32'(W));
            end
        end
        if (ready && busy) check("ready_busy_exclusive", 32'd1, 32'd0);
        ready_q <= ready;
    end

    always @(negedge clk) begin
        if (ready_u && !ready_u_q) begin
            if (exp_u_q.size() == 0) begin
                check("unexpected_ready_u", 32'd1, 32'd0);
            end else begin
                check("res_u", 32'(res_u), 32'(exp_u_q.pop_front()));
                check("latency_u", 32'(cyc - launch_u_q.pop_front()), 32'(W));
            end
        end
        ready_u_q <= ready_u;
    end

    // ---------------- driver tasks ----------------
    // Called at a negedge: presents operands, the next posedge is the launch edge.
    task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic smv, input logic [PW-1:0] expv, input bit track);
        a = av; b = bv; sm = smv; start = 1'b1;
        if (track) begin
            exp_q.push_back(expv);
            launch_q.push_back(cyc + 1);
        end
    endtask

    task automatic pulse(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic smv, input logic [PW-1:0] expv, input bit track);
        @(negedge clk);
        launch(av, bv, smv, expv, track);
        @(negedge clk);
        start = 1'b0;
        a = ~av; b = ~bv; sm = ~smv;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || exp_u_q.size() != 0) && n < 30) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(exp_q.size() + exp_u_q.size()), 32'd0);
    endtask

    typedef struct {
        logic [W-1:0]  av;
        logic [W-1:0]  bv;
        logic          smv;
        logic [PW-1:0] expv;
    } vec_t;

    vec_t dir_vecs[5] = '{
        '{4'h8, 4'h8, 1'b1, 8'h40},   // -8 * -8
        '{4'hD, 4'h5, 1'b1, 8'hF1},   // -3 * 5
        '{4'h7, 4'h8, 1'b1, 8'hC8},   //  7 * -8
        '{4'h8, 4'h8, 1'b0, 8'h40},   //  8 * 8
        '{4'hD, 4'h5, 1'b0, 8'h41}    // 13 * 5
    };

    vec_t held_vecs[8] = '{
        '{4'h3, 4'h5, 1'b0, 8'h0F},
        '{4'hF, 4'hF, 1'b1, 8'h01},   // -1 * -1
        '{4'h9, 4'h2, 1'b1, 8'hF2},   // -7 * 2
        '{4'h9, 4'h2, 1'b0, 8'h12},   //  9 * 2
        '{4'h7, 4'h7, 1'b1, 8'h31},
        '{4'h8, 4'h1, 1'b1, 8'hF8},   // -8 * 1
        '{4'h0, 4'hB, 1'b1, 8'h00},
        '{4'hC, 4'hD, 1'b0, 8'h9C}    // 12 * 13
    };

    // ---------------- stimulus ----------------
    initial begin
        int busy_cycles;
        reset = 1'b1;
        start = 1'b0; sm = 1'b0; a = '0; b = '0;
        start_u = 1'b0; sm_u = 1'b0; a_u = '0; b_u = '0;
        repeat (2) @(negedge clk);
        check("reset_res",   32'(res),    32'd0);
        check("reset_ready", 32'(ready),  32'd0);
        check("reset_busy",  32'(busy),   32'd0);
        check("reset_state", 32'(st_dbg), 32'd0);
        reset = 1'b0;

        // 15*15 unsigned: busy span, then ready/res hold in DONE
        pulse(4'hF, 4'hF, 1'b0, 8'hE1, 1'b1);
        busy_cycles = 1;
        check("busy_after_start", 32'(busy), 32'd1);
        repeat (3) begin
            @(negedge clk);
            if (busy) busy_cycles++;
        end
        check("busy_cycles", 32'(busy_cycles), 32'(W));
        repeat (4) @(negedge clk);
        check("hold_ready", 32'(ready), 32'd1);
        check("hold_res",   32'(res),   32'hE1);
        check("hold_state", 32'(st_dbg), 32'd2);

        foreach (dir_vecs[i]) begin
            pulse(dir_vecs[i].av, dir_vecs[i].bv, dir_vecs[i].smv, dir_vecs[i].expv, 1'b1);
            drain("drain_directed");
        end

        // SIGNED_EN=0 instance ignores signed_mode
        @(negedge clk);
        a_u = 4'hF; b_u = 4'h2; sm_u = 1'b1; start_u = 1'b1;
        exp_u_q.push_back(8'h1E);
        launch_u_q.push_back(cyc + 1);
        @(negedge clk);
        start_u = 1'b0; a_u = '0; b_u = '0;
        drain("drain_unsigned_inst");

        // start during CALC is ignored
        pulse(4'h6, 4'h7, 1'b0, 8'h2A, 1'b1);
        @(negedge clk);
        a = 4'h1; b = 4'h1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain("drain_ignored_start");
        repeat (6) @(negedge clk);
        check("no_second_ready", 32'(ready), 32'd1);
        check("res_after_ignore", 32'(res), 32'h2A);

        // asynchronous reset two cycles into 9*9
        pulse(4'h9, 4'h9, 1'b0, 8'h51, 1'b0);
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check("abort_res",   32'(res),   32'd0);
        check("abort_ready", 32'(ready), 32'd0);
        check("abort_busy",  32'(busy),  32'd0);
        #1 reset = 1'b0;
        repeat (8) @(negedge clk);
        check("no_stale_ready", 32'(ready), 32'd0);
        check("idle_after_abort", 32'(st_dbg), 32'd0);
        pulse(4'h3, 4'h3, 1'b0, 8'h09, 1'b1);
        drain("drain_after_reset");

        // start held high: back-to-back operations
        foreach (held_vecs[i]) begin
            @(negedge clk);
            launch(held_vecs[i].av, held_vecs[i].bv, held_vecs[i].smv, held_vecs[i].expv, 1'b1);
            @(negedge clk);
            a = ~held_vecs[i].av; b = held_vecs[i].bv + 4'h3; sm = ~held_vecs[i].smv;
            repeat (3) @(negedge clk);
        end
        @(negedge clk);
        start = 1'b0;
        drain("drain_held");
        check("held_final_ready", 32'(ready), 32'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
